// File: rtl/as_oq_stats_pkg.sv
// Shared IOQ module-header layout used by the output-queue stages.
package as_oq_stats_pkg;

    // ctrl value that tags the IOQ module header word
    localparam logic [7:0]  IO_QUEUE_STAGE_NUM = 8'hFF;

    // Bit positions of the IOQ header fields inside the 64-bit data word
    localparam int unsigned IOQ_BYTE_LEN_POS   = 0;
    localparam int unsigned IOQ_WORD_LEN_POS   = 32;
    localparam int unsigned IOQ_DST_PORT_POS   = 48;

    localparam int unsigned IOQ_LEN_WIDTH      = 16;

endpackage

// File: rtl/as_sat_counter.sv
// Saturating accumulator: adds inc when en, clamps at all-ones, clr wins.
// Ports: clk, reset (sync, active-low), clr, en, inc[INC_WIDTH], cnt[CNT_WIDTH].
module as_sat_counter
    import as_oq_stats_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned INC_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 en,
    input  logic [INC_WIDTH-1:0] inc,
    output logic [CNT_WIDTH-1:0] cnt
);

    localparam int unsigned SUM_WIDTH = CNT_WIDTH + 1;

    logic [SUM_WIDTH-1:0] sum;

    // One extra bit catches the carry that signals overflow
    assign sum = SUM_WIDTH'(cnt) + SUM_WIDTH'(inc);

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/as_oq_stats.sv
// Per-output-queue packet/byte accounting with a 2-entry pass-through buffer.
// Ports: clk, reset (sync, active-low); in_data/in_ctrl/in_wr/in_rdy upstream;
// out_data/out_ctrl/out_wr/out_rdy downstream; clr_cnt zeroes counters;
// pkt_cnt/byte_cnt packed per queue, hdr_err_cnt for header-less packets.
module as_oq_stats
    import as_oq_stats_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 64,
    parameter int unsigned CTRL_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned NUM_OUTPUT_QUEUES = 8,
    parameter int unsigned CNT_WIDTH         = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [DATA_WIDTH-1:0]                  in_data,
    input  logic [CTRL_WIDTH-1:0]                  in_ctrl,
    input  logic                                   in_wr,
    output logic                                   in_rdy,
    output logic [DATA_WIDTH-1:0]                  out_data,
    output logic [CTRL_WIDTH-1:0]                  out_ctrl,
    output logic                                   out_wr,
    input  logic                                   out_rdy,
    input  logic                                   clr_cnt,
    output logic [NUM_OUTPUT_QUEUES*CNT_WIDTH-1:0] pkt_cnt,
    output logic [NUM_OUTPUT_QUEUES*CNT_WIDTH-1:0] byte_cnt,
    output logic [CNT_WIDTH-1:0]                   hdr_err_cnt
);

    typedef enum logic {
        HDRS    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    // Buffer storage and occupancy
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic [CTRL_WIDTH-1:0] buf_ctrl [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;
    logic                  push;
    logic                  pop;
    logic                  not_empty;

    // Accounting state
    state_t                         state;
    logic                           hdr_seen;
    logic [NUM_OUTPUT_QUEUES-1:0]   dst;
    logic [IOQ_LEN_WIDTH-1:0]       byte_len;
    logic                           commit;

    assign not_empty = (count != 2'd0);
    assign in_rdy    = (count != 2'd2);
    assign out_wr    = not_empty && out_rdy;
    assign out_data  = not_empty ? buf_data[rd_ptr] : '0;
    assign out_ctrl  = not_empty ? buf_ctrl[rd_ptr] : '0;

    // A write while full is dropped so the head entry is never overwritten
    assign push = in_wr && in_rdy;
    assign pop  = out_wr;

    // Two-entry ring buffer
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= in_data;
                buf_ctrl[wr_ptr] <= in_ctrl;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Header/payload tracker, advancing only on departing words
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= HDRS;
            hdr_seen <= 1'b0;
            dst      <= '0;
            byte_len <= '0;
        end else if (out_wr) begin
            case (state)
                HDRS: begin
                    if (out_ctrl == CTRL_WIDTH'(IO_QUEUE_STAGE_NUM)) begin
                        dst      <= out_data[IOQ_DST_PORT_POS +: NUM_OUTPUT_QUEUES];
                        byte_len <= out_data[IOQ_BYTE_LEN_POS +: IOQ_LEN_WIDTH];
                        hdr_seen <= 1'b1;
                    end else if (out_ctrl == '0) begin
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (out_ctrl != '0) begin
                        state    <= HDRS;
                        hdr_seen <= 1'b0;
                    end
                end
                default: state <= HDRS;
            endcase
        end
    end

    // EOP word leaving the stage closes the packet
    assign commit = out_wr && (state == PAYLOAD) && (out_ctrl != '0);

    for (genvar i = 0; i < NUM_OUTPUT_QUEUES; i++) begin : g_queue
        as_sat_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .INC_WIDTH (1)
        ) u_pkt_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (clr_cnt),
            .en    (commit && hdr_seen && dst[i]),
            .inc   (1'b1),
            .cnt   (pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH])
        );

        as_sat_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .INC_WIDTH (IOQ_LEN_WIDTH)
        ) u_byte_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (clr_cnt),
            .en    (commit && hdr_seen && dst[i]),
            .inc   (byte_len),
            .cnt   (byte_cnt[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    as_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .INC_WIDTH (1)
    ) u_hdr_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .en    (commit && !hdr_seen),
        .inc   (1'b1),
        .cnt   (hdr_err_cnt)
    );

endmodule

// File: tb/tb_as_oq_stats.sv
// Self-checking bench for as_oq_stats: random packets against a packet-level model.
module tb_as_oq_stats;
    import as_oq_stats_pkg::*;

    localparam int unsigned DW   = 64;
    localparam int unsigned CWL  = 8;
    localparam int unsigned NQ   = 8;
    // Narrow counters so saturation is reachable in a short run
    localparam int unsigned CNTW = 16;
    localparam longint unsigned MAXC = (64'd1 << CNTW) - 64'd1;

    logic              clk;
    logic              reset;
    logic [DW-1:0]     in_data;
    logic [CWL-1:0]    in_ctrl;
    logic              in_wr;
    logic              in_rdy;
    logic [DW-1:0]     out_data;
    logic [CWL-1:0]    out_ctrl;
    logic              out_wr;
    logic              out_rdy;
    logic              clr_cnt;
    logic [NQ*CNTW-1:0] pkt_cnt;
    logic [NQ*CNTW-1:0] byte_cnt;
    logic [CNTW-1:0]   hdr_err_cnt;

    as_oq_stats #(
        .DATA_WIDTH        (DW),
        .CTRL_WIDTH        (CWL),
        .NUM_OUTPUT_QUEUES (NQ),
        .CNT_WIDTH         (CNTW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_ctrl     (in_ctrl),
        .in_wr       (in_wr),
        .in_rdy      (in_rdy),
        .out_data    (out_data),
        .out_ctrl    (out_ctrl),
        .out_wr      (out_wr),
        .out_rdy     (out_rdy),
        .clr_cnt     (clr_cnt),
        .pkt_cnt     (pkt_cnt),
        .byte_cnt    (byte_cnt),
        .hdr_err_cnt (hdr_err_cnt)
    );

    typedef struct {
        logic [CWL-1:0] ctrl;
        logic [DW-1:0]  data;
        bit             eop;
    } word_t;

    typedef struct {
        bit          has_hdr;
        logic [7:0]  dst;
        int unsigned len;
    } desc_t;

    word_t           wq[$];
    desc_t           dq[$];
    longint unsigned exp_pkt [NQ];
    longint unsigned exp_byte[NQ];
    longint unsigned exp_err;
    int              occ;
    int              out_mode;
    int unsigned     n_cmp;
    int unsigned     n_bad;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint unsigned sat_add(input longint unsigned a, input longint unsigned b);
        return (a + b > MAXC) ? MAXC : a + b;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NQ; i++) begin
            exp_pkt[i]  = 0;
            exp_byte[i] = 0;
        end
        exp_err = 0;
    endfunction

    function automatic void model_commit(input desc_t d);
        if (!d.has_hdr) begin
            exp_err = sat_add(exp_err, 1);
        end else begin
            for (int i = 0; i < NQ; i++) begin
                if (d.dst[i]) begin
                    exp_pkt[i]  = sat_add(exp_pkt[i], 1);
                    exp_byte[i] = sat_add(exp_byte[i], longint'(d.len));
                end
            end
        end
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    // Downstream ready pattern: steady, alternating, or random
    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (out_mode)
                0:       out_rdy = 1'b1;
                1:       out_rdy = ~out_rdy;
                default: out_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: word order, handshake and packet-level accounting model
    always @(negedge clk) begin
        word_t w;
        desc_t d;
        if (reset === 1'b0) begin
            wq.delete();
            dq.delete();
            occ = 0;
            model_clear();
        end else begin
            check("in_rdy", 64'(in_rdy), 64'(occ < 2));
            check("out_wr", 64'(out_wr), 64'((occ > 0) && out_rdy));
            if (occ == 0) begin
                check("idle_data", out_data, 64'd0);
                check("idle_ctrl", 64'(out_ctrl), 64'd0);
            end
            if (out_wr) begin
                if (wq.size() == 0) begin
                    check("spurious_word", 64'd1, 64'd0);
                end else begin
                    w = wq.pop_front();
                    check("out_data", out_data, w.data);
                    check("out_ctrl", 64'(out_ctrl), 64'(w.ctrl));
                    if (w.eop && dq.size() != 0) begin
                        d = dq.pop_front();
                        if (!clr_cnt) model_commit(d);
                    end
                end
            end
            if (clr_cnt) model_clear();
            occ = occ + ((in_wr && occ < 2) ? 1 : 0) - (out_wr ? 1 : 0);
        end
    end

    task automatic put_word(input logic [CWL-1:0] c, input logic [DW-1:0] d, input bit eop);
        int t;
        word_t w;
        t = 0;
        while (!in_rdy) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 1000) begin
                check("in_rdy_timeout", 64'd0, 64'd1);
                return;
            end
        end
        w.ctrl = c;
        w.data = d;
        w.eop  = eop;
        wq.push_back(w);
        in_ctrl = c;
        in_data = d;
        in_wr   = 1'b1;
        @(posedge clk);
        #1;
        in_wr = 1'b0;
    endtask

    task automatic send_pkt(input bit has_hdr, input logic [7:0] dst, input int unsigned len,
                            input int nwords, input bit extra_hdr);
        desc_t       d;
        logic [63:0] hw;
        d.has_hdr = has_hdr;
        d.dst     = dst;
        d.len     = len & 32'hFFFF;
        dq.push_back(d);
        if (has_hdr) begin
            hw = rand64();
            hw[IOQ_DST_PORT_POS +: 8]  = dst;
            hw[IOQ_BYTE_LEN_POS +: 16] = 16'(len);
            put_word(IO_QUEUE_STAGE_NUM, hw, 1'b0);
        end
        if (extra_hdr) put_word(8'($urandom_range(1, 254)), rand64(), 1'b0);
        for (int i = 0; i < nwords - 1; i++) put_word(8'h00, rand64(), 1'b0);
        put_word(8'($urandom_range(1, 255)), rand64(), 1'b1);
    endtask

    task automatic pulse_clr();
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        int t;
        t = 0;
        while (!(wq.size() == 0 && occ == 0)) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 500) begin
                check({tag, "_drain_timeout"}, 64'd0, 64'd1);
                break;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NQ; i++) begin
            check($sformatf("%s_pkt%0d", tag, i), 64'(pkt_cnt[i*CNTW +: CNTW]), exp_pkt[i]);
            check($sformatf("%s_byte%0d", tag, i), 64'(byte_cnt[i*CNTW +: CNTW]), exp_byte[i]);
        end
        check({tag, "_hdr_err"}, 64'(hdr_err_cnt), exp_err);
    endtask

    initial begin
        logic [7:0] rdst;
        n_cmp    = 0;
        n_bad    = 0;
        occ      = 0;
        out_mode = 0;
        reset    = 1'b0;
        in_wr    = 1'b0;
        in_data  = '0;
        in_ctrl  = '0;
        clr_cnt  = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset state
        check("rst_out_wr", 64'(out_wr), 64'd0);
        check("rst_in_rdy", 64'(in_rdy), 64'd1);
        check("rst_out_data", out_data, 64'd0);
        check_counters("reset");

        // Single unicast packet to queue 2
        send_pkt(1'b1, 8'b0000_0100, 60, 8, 1'b0);
        check_counters("single");
        check("single_pkt2_const", 64'(pkt_cnt[2*CNTW +: CNTW]), 64'd1);
        check("single_byte2_const", 64'(byte_cnt[2*CNTW +: CNTW]), 64'd60);

        // Multicast
        send_pkt(1'b1, 8'b0101_0001, 1514, 5, 1'b0);
        check_counters("mcast");
        check("mcast_byte6_const", 64'(byte_cnt[6*CNTW +: CNTW]), 64'd1514);

        // Back-to-back with alternating downstream ready
        out_mode = 1;
        for (int p = 0; p < 20; p++)
            send_pkt(1'b1, 8'($urandom_range(0, 255)), $urandom_range(40, 1514),
                     $urandom_range(2, 6), 1'($urandom_range(0, 1)));
        check_counters("toggle");

        // Packets without an IOQ header
        out_mode = 0;
        send_pkt(1'b0, 8'hFF, 0, 4, 1'b0);
        send_pkt(1'b0, 8'hFF, 0, 3, 1'b1);
        send_pkt(1'b1, 8'h00, 999, 3, 1'b0);
        check_counters("nohdr");

        // Byte-counter saturation on queue 1, then clear coinciding with a commit
        pulse_clr();
        send_pkt(1'b1, 8'h02, 30000, 2, 1'b0);
        send_pkt(1'b1, 8'h02, 30000, 2, 1'b0);
        send_pkt(1'b1, 8'h02, 5435, 2, 1'b0);
        check_counters("presat");
        check("presat_byte1_const", 64'(byte_cnt[1*CNTW +: CNTW]), 64'(MAXC - 100));
        send_pkt(1'b1, 8'h02, 200, 2, 1'b0);
        check_counters("sat");
        check("sat_byte1_const", 64'(byte_cnt[1*CNTW +: CNTW]), 64'(MAXC));
        check("sat_pkt1_const", 64'(pkt_cnt[1*CNTW +: CNTW]), 64'd4);
        send_pkt(1'b1, 8'hFF, 100, 3, 1'b0);
        pulse_clr();
        check_counters("clr_eop");
        for (int i = 0; i < NQ; i++)
            check($sformatf("clr_eop_pkt%0d_const", i), 64'(pkt_cnt[i*CNTW +: CNTW]), 64'd0);

        // Reset in the middle of a payload
        send_pkt(1'b1, 8'h10, 300, 3, 1'b0);
        put_word(IO_QUEUE_STAGE_NUM, rand64(), 1'b0);
        put_word(8'h00, rand64(), 1'b0);
        put_word(8'h00, rand64(), 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("midrst_out_wr", 64'(out_wr), 64'd0);
        check("midrst_in_rdy", 64'(in_rdy), 64'd1);
        check("midrst_pkt4", 64'(pkt_cnt[4*CNTW +: CNTW]), 64'd0);
        check("midrst_err", 64'(hdr_err_cnt), 64'd0);
        send_pkt(1'b1, 8'h08, 77, 4, 1'b0);
        check_counters("postrst");
        check("postrst_pkt3_const", 64'(pkt_cnt[3*CNTW +: CNTW]), 64'd1);

        // Random traffic with random ready and occasional clears
        out_mode = 2;
        for (int p = 0; p < 60; p++) begin
            rdst = 8'($urandom_range(0, 255));
            send_pkt(1'($urandom_range(0, 7) != 0), rdst,
                     ($urandom_range(0, 1) != 0) ? $urandom_range(40, 1514) : $urandom_range(0, 65535),
                     $urandom_range(2, 8), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 15) == 0) pulse_clr();
        end
        check_counters("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
